// File: rtl/spi_slave_sync.sv
// SPI register slave, fully synchronous to the fabric clock: sclk/cs/mosi are
// oversampled through synchronisers, with selectable CPOL/CPHA and a read handshake.
module spi_slave_sync #(
  parameter int unsigned ADRSIZE     = 8,
  parameter int unsigned DATASIZE    = 32,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                sclk,
  input  logic                cs,
  input  logic                mosi,
  output logic                miso,
  output logic                miso_oe,
  output logic [ADRSIZE-1:0]  adr,
  output logic [DATASIZE-1:0] data_wr,
  output logic                wr_en,
  output logic                rd_req,
  input  logic [DATASIZE-1:0] data_rd,
  input  logic                rd_valid,
  output logic                rd_miss,
  output logic                frame_err,
  output logic                busy
);

  localparam int unsigned N  = 1 + ADRSIZE + DATASIZE;
  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [CW-1:0] LastAdr = CW'(ADRSIZE);
  localparam logic [CW-1:0] LastBit = CW'(N - 1);
  localparam logic [CW-1:0] CntOne  = CW'(1);

  typedef enum logic [2:0] {StIdle, StCmd, StAdr, StData, StWaitCs} state_e;

  // Synchronisers and edge detection
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   sclk_lvl, cs_s, mosi_s;
  logic                   lead_edge, trail_edge, sample_edge, shift_edge;
  logic                   cs_fall, cs_rise;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_lvl;
      cs_prev_q   <= cs_s;
    end
  end

  assign sclk_lvl    = sclk_sync_q[SYNC_STAGES-1] ^ CPOL;
  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign lead_edge   = sclk_lvl & ~sclk_prev_q;
  assign trail_edge  = ~sclk_lvl & sclk_prev_q;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  // cs_prev clears on reset, so a frame already running needs a fresh cs high/low
  assign cs_fall     = ~cs_s & cs_prev_q;
  assign cs_rise     = cs_s & ~cs_prev_q;

  // Frame state
  state_e              state_q, state_d;
  logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                rw_q, rw_d;
  logic [ADRSIZE-1:0]  adr_sh_q, adr_sh_d;
  logic [DATASIZE-1:0] rx_sh_q, rx_sh_d;
  logic [DATASIZE-1:0] tx_sh_q, tx_sh_d;
  logic                tx_valid_q, tx_valid_d;
  logic                rd_pend_q, rd_pend_d;
  logic                first_shift_q, first_shift_d;
  logic                miso_q, miso_d;
  logic                miso_oe_q, miso_oe_d;
  logic [ADRSIZE-1:0]  adr_q, adr_d;
  logic [DATASIZE-1:0] data_wr_q, data_wr_d;
  logic                wr_en_q, wr_en_d;
  logic                rd_req_q, rd_req_d;
  logic                rd_miss_q, rd_miss_d;
  logic                frame_err_q, frame_err_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      bit_cnt_q     <= '0;
      rw_q          <= 1'b0;
      adr_sh_q      <= '0;
      rx_sh_q       <= '0;
      tx_sh_q       <= '0;
      tx_valid_q    <= 1'b0;
      rd_pend_q     <= 1'b0;
      first_shift_q <= 1'b0;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      adr_q         <= '0;
      data_wr_q     <= '0;
      wr_en_q       <= 1'b0;
      rd_req_q      <= 1'b0;
      rd_miss_q     <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rw_q          <= rw_d;
      adr_sh_q      <= adr_sh_d;
      rx_sh_q       <= rx_sh_d;
      tx_sh_q       <= tx_sh_d;
      tx_valid_q    <= tx_valid_d;
      rd_pend_q     <= rd_pend_d;
      first_shift_q <= first_shift_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
      adr_q         <= adr_d;
      data_wr_q     <= data_wr_d;
      wr_en_q       <= wr_en_d;
      rd_req_q      <= rd_req_d;
      rd_miss_q     <= rd_miss_d;
      frame_err_q   <= frame_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rw_d          = rw_q;
    adr_sh_d      = adr_sh_q;
    rx_sh_d       = rx_sh_q;
    tx_sh_d       = tx_sh_q;
    tx_valid_d    = tx_valid_q;
    rd_pend_d     = rd_pend_q;
    first_shift_d = first_shift_q;
    miso_d        = miso_q;
    miso_oe_d     = miso_oe_q;
    adr_d         = adr_q;
    data_wr_d     = data_wr_q;
    wr_en_d       = 1'b0;
    rd_req_d      = 1'b0;
    rd_miss_d     = 1'b0;
    frame_err_d   = 1'b0;

    // Register file answer is captured on the first valid beat only
    if (rd_pend_q && rd_valid) begin
      tx_sh_d    = data_rd;
      tx_valid_d = 1'b1;
      rd_pend_d  = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        miso_d     = 1'b0;
        miso_oe_d  = 1'b0;
        tx_valid_d = 1'b0;
        rd_pend_d  = 1'b0;
        if (cs_fall) begin
          state_d       = StCmd;
          bit_cnt_d     = '0;
          miso_oe_d     = 1'b1;
          first_shift_d = 1'b1;
        end
      end

      StCmd, StAdr, StData: begin
        // cs wins over a coincident sclk edge
        if (cs_rise) begin
          state_d     = StIdle;
          frame_err_d = (bit_cnt_q != '0);
          miso_d      = 1'b0;
          miso_oe_d   = 1'b0;
          rd_pend_d   = 1'b0;
          tx_valid_d  = 1'b0;
        end else begin
          if (sample_edge) begin
            bit_cnt_d = bit_cnt_q + CntOne;
            if (state_q == StCmd) begin
              rw_d    = mosi_s;
              state_d = StAdr;
            end else if (state_q == StAdr) begin
              adr_sh_d = ADRSIZE'({adr_sh_q, mosi_s});
              if (bit_cnt_q == LastAdr) begin
                adr_d     = adr_sh_d;
                rd_req_d  = rw_q;
                rd_pend_d = rw_q;
                state_d   = StData;
              end
            end else begin
              rx_sh_d = DATASIZE'({rx_sh_q, mosi_s});
              if (bit_cnt_q == LastBit) begin
                state_d = StWaitCs;
                if (!rw_q) begin
                  data_wr_d = rx_sh_d;
                  wr_en_d   = 1'b1;
                end
              end
            end
          end

          if (shift_edge && state_q == StData && rw_q) begin
            first_shift_d = 1'b0;
            if (tx_valid_q) begin
              miso_d  = tx_sh_q[DATASIZE-1];
              tx_sh_d = tx_sh_q << 1;
            end else if (rd_pend_q && rd_valid) begin
              miso_d     = data_rd[DATASIZE-1];
              tx_sh_d    = data_rd << 1;
              tx_valid_d = 1'b1;
              rd_pend_d  = 1'b0;
            end else begin
              // Too late: drop the request so a later rd_valid cannot load mid-word
              miso_d    = 1'b0;
              rd_pend_d = 1'b0;
              rd_miss_d = first_shift_q;
            end
          end
        end
      end

      StWaitCs: begin
        if (cs_rise) begin
          state_d    = StIdle;
          miso_d     = 1'b0;
          miso_oe_d  = 1'b0;
          tx_valid_d = 1'b0;
          rd_pend_d  = 1'b0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign miso      = miso_q;
  assign miso_oe   = miso_oe_q;
  assign adr       = adr_q;
  assign data_wr   = data_wr_q;
  assign wr_en     = wr_en_q;
  assign rd_req    = rd_req_q;
  assign rd_miss   = rd_miss_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: a mode-0 and a mode-3 instance share cs,
// reset and the read-data port; a bench-side SPI master drives one at a time.
module tb_spi_slave_sync;

  localparam int Half = 10;

  logic        clock, reset, cs, rd_valid;
  logic        sclk0, sclk3, mosi0, mosi3;
  logic [31:0] data_rd;
  logic        miso0, miso_oe0, wr_en0, rd_req0, rd_miss0, frame_err0, busy0;
  logic        miso3, miso_oe3, wr_en3, rd_req3, rd_miss3, frame_err3, busy3;
  logic [7:0]  adr0, adr3;
  logic [31:0] data_wr0, data_wr3;

  logic        m3;
  logic        miso_s, miso_oe_s, wr_en_s, rd_req_s, rd_miss_s, frame_err_s, busy_s;
  logic [7:0]  adr_s;
  logic [31:0] data_wr_s;

  int          n_checks, n_fail;
  int          n_wr, n_rdreq, n_miss, n_ferr;
  int          rsp_delay;
  logic [31:0] rsp_data;

  spi_slave_sync #(.ADRSIZE(8), .DATASIZE(32), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) u_dut0 (
    .clock(clock), .reset(reset), .sclk(sclk0), .cs(cs), .mosi(mosi0), .miso(miso0),
    .miso_oe(miso_oe0), .adr(adr0), .data_wr(data_wr0), .wr_en(wr_en0), .rd_req(rd_req0),
    .data_rd(data_rd), .rd_valid(rd_valid), .rd_miss(rd_miss0), .frame_err(frame_err0),
    .busy(busy0)
  );

  spi_slave_sync #(.ADRSIZE(8), .DATASIZE(32), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2)) u_dut3 (
    .clock(clock), .reset(reset), .sclk(sclk3), .cs(cs), .mosi(mosi3), .miso(miso3),
    .miso_oe(miso_oe3), .adr(adr3), .data_wr(data_wr3), .wr_en(wr_en3), .rd_req(rd_req3),
    .data_rd(data_rd), .rd_valid(rd_valid), .rd_miss(rd_miss3), .frame_err(frame_err3),
    .busy(busy3)
  );

  assign miso_s      = m3 ? miso3 : miso0;
  assign miso_oe_s   = m3 ? miso_oe3 : miso_oe0;
  assign wr_en_s     = m3 ? wr_en3 : wr_en0;
  assign rd_req_s    = m3 ? rd_req3 : rd_req0;
  assign rd_miss_s   = m3 ? rd_miss3 : rd_miss0;
  assign frame_err_s = m3 ? frame_err3 : frame_err0;
  assign busy_s      = m3 ? busy3 : busy0;
  assign adr_s       = m3 ? adr3 : adr0;
  assign data_wr_s   = m3 ? data_wr3 : data_wr0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Pulse counters for the selected instance, sampled mid-cycle
  initial begin
    n_wr = 0; n_rdreq = 0; n_miss = 0; n_ferr = 0;
  end
  always @(negedge clock) begin
    if (wr_en_s) n_wr++;
    if (rd_req_s) n_rdreq++;
    if (rd_miss_s) n_miss++;
    if (frame_err_s) n_ferr++;
  end

  // Register-file model: answers each rd_req after rsp_delay clocks
  initial begin
    rd_valid = 1'b0;
    data_rd  = '0;
    forever begin
      @(negedge clock);
      if (rd_req_s) begin
        repeat (rsp_delay) @(posedge clock);
        #1;
        data_rd  = rsp_data;
        rd_valid = 1'b1;
        @(posedge clock);
        #1;
        rd_valid = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_sclk(input logic v);
    if (m3) sclk3 = v;
    else    sclk0 = v;
  endtask

  task automatic set_mosi(input logic v);
    if (m3) mosi3 = v;
    else    mosi0 = v;
  endtask

  function automatic logic bit_at(input logic [40:0] f, input int n, input int i);
    if (i < n && i < 41) return f[40-i];
    return 1'b1;
  endfunction

  // SPI master for the selected mode; captures the 32 data-phase miso bits
  task automatic spi_xfer(input logic [40:0] frame, input int nbits, input int extra,
                          input bit drop_cs, input bit raise_cs, output logic [31:0] cap);
    logic cpol, cpha;
    cpol = m3;
    cpha = m3;
    cap  = '0;
    if (!cpha) set_mosi(bit_at(frame, nbits, 0));
    if (drop_cs) cs = 1'b0;
    wait_clks(Half);
    for (int i = 0; i < nbits + extra; i++) begin
      if (!cpha && i >= 9 && i < 41 && i < nbits) cap = {cap[30:0], miso_s};
      set_sclk(~cpol);
      if (cpha) set_mosi(bit_at(frame, nbits, i));
      wait_clks(Half);
      if (cpha && i >= 9 && i < 41 && i < nbits) cap = {cap[30:0], miso_s};
      set_sclk(cpol);
      if (!cpha) set_mosi(bit_at(frame, nbits, i + 1));
      wait_clks(Half);
    end
    if (raise_cs) begin
      cs = 1'b1;
      wait_clks(Half);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_clks(3);
    n_checks++;
    if ({miso0, miso_oe0, wr_en0, rd_req0, rd_miss0, frame_err0, busy0} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctl0: got %b required 0000000",
               {miso0, miso_oe0, wr_en0, rd_req0, rd_miss0, frame_err0, busy0});
    end
    n_checks++;
    if ({adr0, data_wr0} !== 40'h0) begin
      n_fail++;
      $display("FAIL reset_regs0: got %h required 0", {adr0, data_wr0});
    end
    n_checks++;
    if ({miso3, miso_oe3, wr_en3, rd_req3, rd_miss3, frame_err3, busy3, adr3, data_wr3}
        !== 47'h0) begin
      n_fail++;
      $display("FAIL reset_all3: got %h required 0",
               {miso3, miso_oe3, wr_en3, rd_req3, rd_miss3, frame_err3, busy3, adr3, data_wr3});
    end
    reset = 1'b0;
    wait_clks(6);
    n_checks++;
    if ({busy0, busy3, miso_oe0, miso_oe3} !== 4'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b required 0000", {busy0, busy3, miso_oe0, miso_oe3});
    end
  endtask

  task automatic test_write(input logic mode);
    int wr0, rq0, fe0;
    logic [31:0] cap;
    m3 = mode;
    wr0 = n_wr; rq0 = n_rdreq; fe0 = n_ferr;
    spi_xfer({1'b0, 8'h5A, 32'hDEADBEEF}, 41, 0, 1'b1, 1'b1, cap);
    wait_clks(4);
    n_checks++;
    if (n_wr - wr0 != 1) begin
      n_fail++;
      $display("FAIL write_m%0d_wr_en_count: got %0d required 1", mode, n_wr - wr0);
    end
    n_checks++;
    if (n_rdreq - rq0 != 0 || n_ferr - fe0 != 0) begin
      n_fail++;
      $display("FAIL write_m%0d_no_rdreq_ferr: got %0d/%0d required 0/0", mode,
               n_rdreq - rq0, n_ferr - fe0);
    end
    n_checks++;
    if (adr_s !== 8'h5A) begin
      n_fail++;
      $display("FAIL write_m%0d_adr: got %h required 5a", mode, adr_s);
    end
    n_checks++;
    if (data_wr_s !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL write_m%0d_data: got %h required deadbeef", mode, data_wr_s);
    end
    n_checks++;
    if ({busy_s, miso_oe_s, miso_s} !== 3'b0) begin
      n_fail++;
      $display("FAIL write_m%0d_idle: got %b required 000", mode, {busy_s, miso_oe_s, miso_s});
    end
  endtask

  task automatic test_read(input logic mode);
    int wr0, rq0, ms0;
    logic [31:0] cap;
    m3 = mode;
    rsp_delay = 2;
    rsp_data  = 32'hCAFEF00D;
    wr0 = n_wr; rq0 = n_rdreq; ms0 = n_miss;
    spi_xfer({1'b1, 8'h12, 32'h0}, 41, 0, 1'b1, 1'b1, cap);
    wait_clks(4);
    n_checks++;
    if (cap !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL read_m%0d_capture: got %h required cafef00d", mode, cap);
    end
    n_checks++;
    if (n_rdreq - rq0 != 1) begin
      n_fail++;
      $display("FAIL read_m%0d_rd_req_count: got %0d required 1", mode, n_rdreq - rq0);
    end
    n_checks++;
    if (n_miss - ms0 != 0 || n_wr - wr0 != 0) begin
      n_fail++;
      $display("FAIL read_m%0d_no_miss_wr: got %0d/%0d required 0/0", mode,
               n_miss - ms0, n_wr - wr0);
    end
    n_checks++;
    if (adr_s !== 8'h12) begin
      n_fail++;
      $display("FAIL read_m%0d_adr: got %h required 12", mode, adr_s);
    end
  endtask

  task automatic test_read_late();
    int wr0, rq0, ms0;
    logic [31:0] cap;
    m3 = 1'b0;
    rsp_delay = 30;
    rsp_data  = 32'h13572468;
    wr0 = n_wr; rq0 = n_rdreq; ms0 = n_miss;
    spi_xfer({1'b1, 8'h77, 32'h0}, 41, 0, 1'b1, 1'b1, cap);
    wait_clks(4);
    rsp_delay = 2;
    n_checks++;
    if (n_miss - ms0 != 1) begin
      n_fail++;
      $display("FAIL late_rd_miss_count: got %0d required 1", n_miss - ms0);
    end
    n_checks++;
    if (cap !== 32'h0) begin
      n_fail++;
      $display("FAIL late_capture: got %h required 00000000", cap);
    end
    n_checks++;
    if (n_rdreq - rq0 != 1 || n_wr - wr0 != 0) begin
      n_fail++;
      $display("FAIL late_rdreq_wr: got %0d/%0d required 1/0", n_rdreq - rq0, n_wr - wr0);
    end
  endtask

  task automatic test_abort();
    int wr0, fe0;
    logic [31:0] cap;
    m3 = 1'b0;
    wr0 = n_wr; fe0 = n_ferr;
    spi_xfer({1'b0, 8'h3C, 32'hA5A5A5A5}, 20, 0, 1'b1, 1'b0, cap);
    wait_clks(2);
    n_checks++;
    if (busy_s !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_busy_before: got %b required 1", busy_s);
    end
    cs = 1'b1;
    wait_clks(6);
    n_checks++;
    if ({busy_s, miso_oe_s} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_idle_after: got %b required 00", {busy_s, miso_oe_s});
    end
    n_checks++;
    if (n_ferr - fe0 != 1 || n_wr - wr0 != 0) begin
      n_fail++;
      $display("FAIL abort_ferr_wr: got %0d/%0d required 1/0", n_ferr - fe0, n_wr - wr0);
    end
    n_checks++;
    if (adr_s !== 8'h3C || data_wr_s !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL abort_regs: got %h/%h required 3c/deadbeef", adr_s, data_wr_s);
    end
    wait_clks(Half);
  endtask

  task automatic test_back_to_back();
    int wr0, fe0;
    logic [31:0] cap;
    m3 = 1'b0;
    wr0 = n_wr;
    spi_xfer({1'b0, 8'h5A, 32'h0BADF00D}, 41, 5, 1'b1, 1'b1, cap);
    wait_clks(4);
    n_checks++;
    if (n_wr - wr0 != 1 || data_wr_s !== 32'h0BADF00D) begin
      n_fail++;
      $display("FAIL extra_sclk_single_wr: got %0d/%h required 1/0badf00d", n_wr - wr0,
               data_wr_s);
    end
    spi_xfer({1'b0, 8'hC3, 32'h12345678}, 15, 0, 1'b1, 1'b0, cap);
    reset = 1'b1;
    wait_clks(3);
    reset = 1'b0;
    wait_clks(2);
    n_checks++;
    if ({miso0, miso_oe0, wr_en0, rd_req0, rd_miss0, frame_err0, busy0, adr0, data_wr0}
        !== 47'h0) begin
      n_fail++;
      $display("FAIL midframe_reset_outputs: got %h required 0",
               {miso0, miso_oe0, wr_en0, rd_req0, rd_miss0, frame_err0, busy0, adr0, data_wr0});
    end
    wr0 = n_wr; fe0 = n_ferr;
    spi_xfer({1'b0, 8'hC3, 32'h12345678}, 5, 0, 1'b0, 1'b1, cap);
    wait_clks(4);
    n_checks++;
    if (busy_s !== 1'b0 || n_wr - wr0 != 0 || n_ferr - fe0 != 0) begin
      n_fail++;
      $display("FAIL no_resync_after_reset: got busy=%b wr=%0d ferr=%0d required 0/0/0",
               busy_s, n_wr - wr0, n_ferr - fe0);
    end
    wr0 = n_wr;
    spi_xfer({1'b0, 8'h01, 32'h00000001}, 41, 0, 1'b1, 1'b1, cap);
    wait_clks(4);
    n_checks++;
    if (n_wr - wr0 != 1) begin
      n_fail++;
      $display("FAIL third_frame_wr_count: got %0d required 1", n_wr - wr0);
    end
    n_checks++;
    if (adr_s !== 8'h01 || data_wr_s !== 32'h00000001) begin
      n_fail++;
      $display("FAIL third_frame_regs: got %h/%h required 01/00000001", adr_s, data_wr_s);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    m3        = 1'b0;
    reset     = 1'b1;
    cs        = 1'b1;
    sclk0     = 1'b0;
    sclk3     = 1'b1;
    mosi0     = 1'b0;
    mosi3     = 1'b0;
    rsp_delay = 2;
    rsp_data  = '0;
    test_reset();
    test_write(1'b0);
    test_read(1'b0);
    test_write(1'b1);
    test_read(1'b1);
    test_read_late();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_sync.md
Name: spi_slave_sync

Overview:
- Parametrised successor to the team's SPI register slave.
- The whole block runs in the fabric clock domain: sclk, cs and mosi are oversampled through synchronisers, not used as clocks.
- Adds selectable SPI mode (CPOL/CPHA), a read/write command bit, a request/valid read handshake, single-cycle write strobes and abort detection.
- Sits between the board SPI pins and the register file.

Parameters:
- ADRSIZE, 8: address field width in bits.
- DATASIZE, 32: data field width in bits.
- CPOL, 0: idle level of sclk.
- CPHA, 0: 0 = sample on leading edge and shift on trailing edge; 1 = shift on leading edge and sample on trailing edge.
- SYNC_STAGES, 2: synchroniser depth on sclk, cs and mosi (minimum 2).

Ports:
- clock, in, 1: fabric clock.
- reset, in, 1: asynchronous, active-high.
- sclk, in, 1: SPI clock (asynchronous to clock).
- cs, in, 1: chip select, active-low.
- mosi, in, 1: serial data in.
- miso, out, 1: serial data out.
- miso_oe, out, 1: high while cs is low; drives the tristate at top level.
- adr, out, ADRSIZE: latched address.
- data_wr, out, DATASIZE: latched write data.
- wr_en, out, 1: one-clock write strobe.
- rd_req, out, 1: one-clock read request.
- data_rd, in, DATASIZE: read data from the register file.
- rd_valid, in, 1: qualifies data_rd.
- rd_miss, out, 1: one-clock pulse; read data arrived too late.
- frame_err, out, 1: one-clock pulse; frame aborted.
- busy, out, 1: high whenever state is not IDLE.

Behaviour:
- Reset (asynchronous): all outputs 0, state IDLE, counters 0, synchronisers cleared.
- Synchronisers: sclk, cs and mosi each pass through SYNC_STAGES flops. Edges are detected on the synchronised sclk XOR CPOL; leading edge = 0->1 of that signal.
- sclk limit: sclk frequency must not exceed f_clock / (2*(SYNC_STAGES+2)).
- Frame format, MSB first: 1 R/W bit (1 = read), then ADRSIZE address bits, then DATASIZE data bits. Total N = 1+ADRSIZE+DATASIZE.
- bit_cnt width: clog2(N+1).
- States: IDLE, CMD, ADR, DATA, WAIT_CS.
- IDLE -> CMD on synchronised cs falling. bit_cnt=0, miso_oe=1, miso=0.
- CMD -> ADR after 1 sample edge. R/W bit stored.
- ADR -> DATA after ADRSIZE sample edges. adr is updated the clock after the last address sample. For reads, rd_req pulses in that same clock.
- Read data load: data_rd is loaded into the tx shift register on the first clock with rd_valid=1 while a read is pending. rd_valid outside a pending read is ignored.
- Read shift-out: miso shifts MSB first on each shift edge. For CPHA=0 the first data bit is presented on the trailing edge of the last address bit.
- Read too late: if the first data shift edge arrives with no rd_valid yet, rd_miss pulses and miso drives 0 for the whole data phase. A later rd_valid is ignored.
- Miso outside read data: 0 during CMD and ADR phases and during write frames.
- DATA -> WAIT_CS after DATASIZE sample edges. For writes, data_wr is updated and wr_en pulses exactly 1 clock after the final sample edge. Reads produce no wr_en and ignore mosi data bits.
- WAIT_CS: further sclk edges are ignored (no second strobe). Synchronised cs rising -> IDLE with no error.
- cs rising in CMD/ADR/DATA with bit_cnt>0: frame_err pulse, no wr_en, return to IDLE. adr keeps any already-latched value. A pending read is dropped; a late rd_valid is ignored.
- cs rising with bit_cnt==0: silent return to IDLE.
- miso_oe deasserts and miso returns to 0 the clock after synchronised cs rises.
- Same-clock cs rise and sample edge: cs wins; the edge is discarded.
- Reset mid-frame: immediate return to IDLE. A frame already in progress on the bus is not resynchronised until cs goes high then low again.

Test Plan:
- CPOL=0, CPHA=0, write frame 0 / 0x5A / 0xDEADBEEF -> exactly one wr_en, adr=0x5A, data_wr=0xDEADBEEF, rd_req never asserted.
- Read frame 1 / 0x12, rd_valid with data_rd=0xCAFEF00D two clocks after rd_req -> master captures 0xCAFEF00D; rd_miss=0, wr_en=0.
- CPOL=1, CPHA=1: repeat both frames above -> identical register-side results and identical master-captured data.
- Read frame with rd_valid withheld past the first data shift edge -> one rd_miss pulse, master captures 0x00000000.
- Write frame with cs raised after 20 bits -> one frame_err pulse, wr_en never asserted, adr=the address sent, busy low after cs sync.
- Write frame followed by 5 extra sclk cycles before cs rise, then assert reset mid-frame on a second write -> first frame gives one wr_en only; after reset all outputs 0, and a third full frame 0 / 0x01 / 0x00000001 writes correctly.
